// File: rtl/motor_dense_serial_2out_if.sv
// ============================================================================
// Module      : motor_dense_serial_2out_if
// Description : Bundle of control, sample-stream, weight-ROM, bias and result
//               signals for the serial two-neuron dense layer.
//               slave  modport : the dense engine (motor_dense_serial_2out)
//               master modport : whoever starts it, feeds samples and weights
// Signals     : ap_start / ap_idle / ap_done / ap_ready  HLS-style control
//               x_data, x_valid / x_ready                 sample handshake
//               w_addr -> w_data0, w_data1                weight ROM (1-cycle)
//               b0, b1                                    biases
//               ap_return_0, ap_return_1                  neuron results
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface motor_dense_serial_2out_if #(
  parameter int N_IN   = 8,
  parameter int DATA_W = 18
);
  localparam int c_ADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                      ap_start;
  logic                      ap_idle;
  logic                      ap_done;
  logic                      ap_ready;
  logic signed [DATA_W-1:0]  x_data;
  logic                      x_valid;
  logic                      x_ready;
  logic [c_ADDR_W-1:0]       w_addr;
  logic signed [DATA_W-1:0]  w_data0;
  logic signed [DATA_W-1:0]  w_data1;
  logic signed [DATA_W-1:0]  b0;
  logic signed [DATA_W-1:0]  b1;
  logic signed [DATA_W-1:0]  ap_return_0;
  logic signed [DATA_W-1:0]  ap_return_1;

  modport slave (
    input  ap_start, x_data, x_valid, w_data0, w_data1, b0, b1,
    output ap_idle, ap_done, ap_ready, x_ready, w_addr, ap_return_0, ap_return_1
  );

  modport master (
    output ap_start, x_data, x_valid, w_data0, w_data1, b0, b1,
    input  ap_idle, ap_done, ap_ready, x_ready, w_addr, ap_return_0, ap_return_1
  );
endinterface

`default_nettype wire

// File: rtl/motor_dense_serial_2out.sv
// ============================================================================
// Module      : motor_dense_serial_2out
// Description : Serial dense layer with two output neurons, ap_fixed<18,7>
//               arithmetic (11 fractional bits). One sample per transfer is
//               multiplied by two weights fetched from an external ROM and
//               accumulated on top of the bias.
// Ports       : ap_clk    - clock, rising edge
//               ap_rst_n  - asynchronous active-low reset (release is
//                           re-timed internally through two flops)
//               bus       - motor_dense_serial_2out_if.slave (control,
//                           sample handshake, weight ROM, biases, results)
// Config      : MOTOR_DENSE_SAT_EN defined   -> outputs saturate (AP_SAT)
//               MOTOR_DENSE_SAT_EN undefined -> outputs wrap     (AP_WRAP)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module motor_dense_serial_2out #(
  parameter int N_IN   = 8,
  parameter int DATA_W = 18
) (
  input  wire logic                 ap_clk,
  input  wire logic                 ap_rst_n,
  motor_dense_serial_2out_if.slave  bus
);

  localparam int c_ADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int c_FRAC_W = 11;
  localparam int c_PROD_W = 2 * DATA_W;
  localparam int c_ACC_W  = 2 * DATA_W + 4;
  localparam logic [c_ADDR_W-1:0] c_LAST_IDX = c_ADDR_W'(N_IN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Reset: assertion is immediate, release is delayed by two clock edges so
  // the FSM never sees a transition on the edge where ap_rst_n rises.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                    r_state;
  logic [c_ADDR_W-1:0]       r_idx;
  logic signed [DATA_W-1:0]  r_x;
  logic                      r_mac_pend;
  logic signed [c_ACC_W-1:0] r_acc0;
  logic signed [c_ACC_W-1:0] r_acc1;
  logic signed [DATA_W-1:0]  r_ret0;
  logic signed [DATA_W-1:0]  r_ret1;
  logic                      r_idle;
  logic                      r_done;
  logic                      r_ready;
  logic                      r_x_ready;

  logic                      w_xfer;
  logic signed [c_PROD_W-1:0] w_prod0;
  logic signed [c_PROD_W-1:0] w_prod1;
  logic signed [c_ACC_W-1:0] w_acc_next0;
  logic signed [c_ACC_W-1:0] w_acc_next1;
  logic signed [c_ACC_W-1:0] w_bias0;
  logic signed [c_ACC_W-1:0] w_bias1;
  logic signed [DATA_W-1:0]  w_ret_next0;
  logic signed [DATA_W-1:0]  w_ret_next1;

  // x_ready is only ever high in ACC, so this also gates out-of-state offers
  assign w_xfer = bus.x_valid & r_x_ready;

  // The registered sample meets the weight the ROM returns one cycle after
  // its address was presented, i.e. on the cycle after the transfer.
  assign w_prod0 = r_x * bus.w_data0;
  assign w_prod1 = r_x * bus.w_data1;

  assign w_acc_next0 = r_acc0 + (r_mac_pend ? c_ACC_W'(w_prod0) : c_ACC_W'(0));
  assign w_acc_next1 = r_acc1 + (r_mac_pend ? c_ACC_W'(w_prod1) : c_ACC_W'(0));

  // Bias aligned to the product's 22 fractional bits
  assign w_bias0 = c_ACC_W'(bus.b0) <<< c_FRAC_W;
  assign w_bias1 = c_ACC_W'(bus.b1) <<< c_FRAC_W;

  // --------------------------------------------------------------------------
  // Output reduction: arithmetic shift (floor) back to 11 fractional bits,
  // then clamp or wrap to DATA_W. Uses the accumulator value including the
  // MAC that completes in DRAIN.
  // --------------------------------------------------------------------------
`ifdef MOTOR_DENSE_SAT_EN
  localparam logic signed [DATA_W-1:0] c_OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] c_OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [c_ACC_W-1:0] w_shift0;
  logic signed [c_ACC_W-1:0] w_shift1;

  always_comb begin
    w_shift0 = w_acc_next0 >>> c_FRAC_W;
    w_shift1 = w_acc_next1 >>> c_FRAC_W;

    if (w_shift0 > c_ACC_W'(c_OUT_MAX)) begin
      w_ret_next0 = c_OUT_MAX;
    end else if (w_shift0 < c_ACC_W'(c_OUT_MIN)) begin
      w_ret_next0 = c_OUT_MIN;
    end else begin
      w_ret_next0 = w_shift0[DATA_W-1:0];
    end

    if (w_shift1 > c_ACC_W'(c_OUT_MAX)) begin
      w_ret_next1 = c_OUT_MAX;
    end else if (w_shift1 < c_ACC_W'(c_OUT_MIN)) begin
      w_ret_next1 = c_OUT_MIN;
    end else begin
      w_ret_next1 = w_shift1[DATA_W-1:0];
    end
  end
`else
  // Taking the bit field directly is the shift-then-truncate result
  assign w_ret_next0 = w_acc_next0[c_FRAC_W +: DATA_W];
  assign w_ret_next1 = w_acc_next1[c_FRAC_W +: DATA_W];
`endif

  // --------------------------------------------------------------------------
  // Control FSM and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_x        <= '0;
      r_mac_pend <= 1'b0;
      r_acc0     <= '0;
      r_acc1     <= '0;
      r_ret0     <= '0;
      r_ret1     <= '0;
      r_idle     <= 1'b1;
      r_done     <= 1'b0;
      r_ready    <= 1'b0;
      r_x_ready  <= 1'b0;
    end else begin
      // A pending MAC always retires, whether or not a new sample arrives
      if (r_mac_pend) begin
        r_acc0 <= w_acc_next0;
        r_acc1 <= w_acc_next1;
      end
      r_mac_pend <= w_xfer;
      if (w_xfer) begin
        r_x <= bus.x_data;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.ap_start) begin
            r_acc0    <= w_bias0;
            r_acc1    <= w_bias1;
            r_idx     <= '0;
            r_idle    <= 1'b0;
            r_x_ready <= 1'b1;
            r_state   <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_xfer) begin
            if (r_idx == c_LAST_IDX) begin
              r_idx     <= '0;
              r_x_ready <= 1'b0;
              r_state   <= S_DRAIN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          r_ret0  <= w_ret_next0;
          r_ret1  <= w_ret_next1;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ap_idle     = r_idle;
  assign bus.ap_done     = r_done;
  assign bus.ap_ready    = r_ready;
  assign bus.x_ready     = r_x_ready;
  assign bus.w_addr      = r_idx;
  assign bus.ap_return_0 = r_ret0;
  assign bus.ap_return_1 = r_ret1;

endmodule

`default_nettype wire

// File: tb/tb_motor_dense_serial_2out.sv
// ============================================================================
// Module      : tb_motor_dense_serial_2out
// Description : Self-checking bench for motor_dense_serial_2out. A table of
//               directed runs (weights, samples, biases, stall pattern and the
//               hand-computed results/latency) is applied in a loop, followed
//               by reset-state, idle-handshake and mid-run reset sequences.
//               Expectations for the overflow run follow MOTOR_DENSE_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_motor_dense_serial_2out;

  localparam int N_IN   = 8;
  localparam int DATA_W = 18;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  always #5 ap_clk = ~ap_clk;

  motor_dense_serial_2out_if #(.N_IN(N_IN), .DATA_W(DATA_W)) bus ();

  motor_dense_serial_2out #(.N_IN(N_IN), .DATA_W(DATA_W)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  // Weight ROM with one cycle of read latency
  logic signed [DATA_W-1:0] rom0 [N_IN];
  logic signed [DATA_W-1:0] rom1 [N_IN];
  logic signed [DATA_W-1:0] xs   [N_IN];

  always @(posedge ap_clk) begin
    bus.w_data0 <= rom0[bus.w_addr];
    bus.w_data1 <= rom1[bus.w_addr];
  end

  typedef struct {
    string name;
    int    x0;
    int    x_step;
    int    w0;
    int    w1;
    int    b0;
    int    b1;
    bit    gap;
    int    exp_r0;
    int    exp_r1;
    int    exp_lat;
  } vec_t;

  vec_t tbl [7];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < N_IN; i++) begin
      rom0[i] = DATA_W'(v.w0);
      rom1[i] = DATA_W'(v.w1);
      xs[i]   = DATA_W'(v.x0 + i * v.x_step);
    end
    bus.b0 = DATA_W'(v.b0);
    bus.b1 = DATA_W'(v.b1);
  endtask

  // Cycle 0 is the cycle ap_start is high; cycle c is observed at its negedge
  task automatic run_vec(input vec_t v, input bit spam);
    int k     = 0;
    int lat   = -1;
    int dones = 0;
    bit xfer  = 1'b0;
    load_vec(v);
    @(negedge ap_clk);
    check({v.name, "/idle_before"}, int'(bus.ap_idle), 1);
    bus.ap_start = 1'b1;
    bus.x_valid  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge ap_clk);
      bus.ap_start = spam && (c == 3 || c == 5);
      if (xfer) k++;
      if (bus.ap_done) begin
        dones++;
        if (lat < 0) begin
          lat = c;
          check({v.name, "/ready"}, int'(bus.ap_ready), 1);
          check({v.name, "/ret0"}, int'(bus.ap_return_0), v.exp_r0);
          check({v.name, "/ret1"}, int'(bus.ap_return_1), v.exp_r1);
        end
      end
      if (lat > 0 && c == lat + 1) begin
        check({v.name, "/done_pulse"}, int'(bus.ap_done), 0);
        check({v.name, "/idle_after"}, int'(bus.ap_idle), 1);
      end
      // Keep offering data even after all samples are sent
      bus.x_valid = !v.gap || (c % 2 == 0);
      if (k < N_IN) bus.x_data = xs[k];
      else          bus.x_data = 18'sh15555;
      xfer = bus.x_valid && bus.x_ready;
      if (xfer) check({v.name, "/xfer_addr"}, int'(bus.w_addr), k);
    end
    check({v.name, "/latency"}, lat, v.exp_lat);
    check({v.name, "/done_count"}, dones, 1);
    check({v.name, "/ret0_hold"}, int'(bus.ap_return_0), v.exp_r0);
    bus.x_valid  = 1'b0;
    bus.ap_start = 1'b0;
  endtask

  initial begin
    int k;
    bit xf;

    tbl[0] = '{"unit",   2048,    0,   2048,   -1024,    0,     0, 1'b0, 16384,  -8192, 10};
    tbl[1] = '{"bias",      0,    0,   2048,   -1024, 1024, -1024, 1'b0,  1024,  -1024, 10};
    tbl[2] = '{"gap",    2048,    0,   2048,   -1024,    0,     0, 1'b1, 16384,  -8192, 18};
`ifdef MOTOR_DENSE_SAT_EN
    tbl[3] = '{"ovf",  131071,    0, 131071, -131072,    0,     0, 1'b0, 131071, -131072, 10};
`else
    tbl[3] = '{"ovf",  131071,    0, 131071, -131072,    0,     0, 1'b0, -1024,    512, 10};
`endif
    tbl[4] = '{"floor",     1,    0,      1,      -1,    0,     0, 1'b0,     0,     -1, 10};
    tbl[5] = '{"ramp",      0, 2048,   2048,   -2048,  512,     0, 1'b0, 57856, -57344, 10};
    tbl[6] = '{"neg",   -2048,    0,  -2048,    2048,   -1,     1, 1'b0, 16383, -16383, 10};

    bus.ap_start = 1'b0;
    bus.x_valid  = 1'b0;
    bus.x_data   = '0;
    bus.b0       = '0;
    bus.b1       = '0;
    for (int i = 0; i < N_IN; i++) begin
      rom0[i] = '0;
      rom1[i] = '0;
      xs[i]   = '0;
    end

    // Reset state
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    check("rst/idle",    int'(bus.ap_idle), 1);
    check("rst/done",    int'(bus.ap_done), 0);
    check("rst/ready",   int'(bus.ap_ready), 0);
    check("rst/x_ready", int'(bus.x_ready), 0);
    check("rst/w_addr",  int'(bus.w_addr), 0);
    check("rst/ret0",    int'(bus.ap_return_0), 0);
    check("rst/ret1",    int'(bus.ap_return_1), 0);
    ap_rst_n = 1'b1;
    repeat (4) @(negedge ap_clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], 1'b0);
    end

    // Offers in IDLE are not accepted
    bus.x_valid = 1'b1;
    @(negedge ap_clk);
    check("idle/x_ready", int'(bus.x_ready), 0);
    check("idle/w_addr",  int'(bus.w_addr), 0);
    bus.x_valid = 1'b0;

    // Abort after the 4th transfer
    load_vec(tbl[0]);
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    k  = 0;
    xf = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
      if (xf) k++;
      if (k == 4) break;
      bus.x_valid = 1'b1;
      bus.x_data  = xs[k];
      xf = bus.x_valid && bus.x_ready;
    end
    check("abort/xfers", k, 4);
    ap_rst_n    = 1'b0;
    bus.x_valid = 1'b0;
    #1;
    check("abort/idle",    int'(bus.ap_idle), 1);
    check("abort/x_ready", int'(bus.x_ready), 0);
    check("abort/w_addr",  int'(bus.w_addr), 0);
    check("abort/done",    int'(bus.ap_done), 0);
    check("abort/ret0",    int'(bus.ap_return_0), 0);
    check("abort/ret1",    int'(bus.ap_return_1), 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (4) @(negedge ap_clk);
    run_vec(tbl[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motor_dense_serial_2out.md
MOTOR_DENSE_SERIAL_2OUT -- requirements
Module: motor_dense_serial_2out

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning input vector length (2..64).
REQ-002 SHALL have parameter DATA_W, default 18, meaning the word width of ap_fixed<18,7> with 11 fractional bits.
REQ-003 SHALL have port ap_clk  in  1  clock, rising edge.
REQ-004 SHALL have port ap_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ap_start  in  1  start one dense evaluation.
REQ-006 SHALL have ports ap_idle, ap_done, ap_ready  out  1 each  HLS-style control status.
REQ-007 SHALL have port x_data  in  DATA_W  signed input sample.
REQ-008 SHALL have ports x_valid (in, 1) and x_ready (out, 1)  sample handshake.
REQ-009 SHALL have port w_addr  out  clog2(N_IN)  weight ROM address.
REQ-010 SHALL have ports w_data0, w_data1  in  DATA_W  signed weights, valid one cycle after w_addr.
REQ-011 SHALL have ports b0, b1  in  DATA_W  signed biases, stable while busy.
REQ-012 SHALL have ports ap_return_0, ap_return_1  out  DATA_W  signed neuron outputs feeding the downstream ReLU.

Function
REQ-013 SHALL implement FSM IDLE -> ACC -> DRAIN -> DONE -> IDLE.
REQ-014 In IDLE, ap_idle SHALL be 1, and ap_start=1 SHALL load acc0=b0<<11 and acc1=b1<<11 (sign-extended), clear the index to 0, and enter ACC.
REQ-015 In ACC, x_ready SHALL be 1, and a transfer SHALL occur when x_valid&x_ready; w_addr SHALL equal the index of the sample being transferred.
REQ-016 Each transfer SHALL register x and increment the index; on the following cycle acc_k SHALL become acc_k + x*w_data_k (36-bit full product added to a 40-bit signed accumulator).
REQ-017 x_valid gaps SHALL stall without corrupting the accumulators; a pending multiply SHALL complete regardless of a stall.
REQ-018 After the N_IN-th transfer, x_ready SHALL drop the next cycle and the FSM SHALL enter DRAIN for one cycle to absorb the last MAC.
REQ-019 On DRAIN -> DONE, ap_return_k SHALL be registered as acc_k >>> 11 (truncation toward minus infinity) reduced to DATA_W per REQ-029/030.
REQ-020 In DONE, ap_done and ap_ready SHALL pulse for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 ap_return_0/1 SHALL hold their values until the next DONE.
REQ-022 ap_start while not IDLE SHALL be ignored.
REQ-023 Latency SHALL be N_IN+2 cycles from the ap_start cycle to the ap_done cycle with x_valid held high.
REQ-024 x_ready SHALL be 0 outside ACC; samples offered outside ACC SHALL not be consumed.

Reset
REQ-025 ap_rst_n=0 SHALL asynchronously force IDLE, clear the accumulators and index, and set ap_return_0/1=0, ap_done=0, ap_ready=0, x_ready=0, w_addr=0, and ap_idle=1.
REQ-026 Reset asserted mid-ACC SHALL abort the evaluation; a following ap_start SHALL restart from bias with no residue.
REQ-027 Reset release SHALL be synchronous to ap_clk internally (two-flop release) so that no FSM transition occurs on the release edge.

Configuration
REQ-028 Macro MOTOR_DENSE_SAT_EN SHALL select the output overflow mode.
REQ-029 With MOTOR_DENSE_SAT_EN defined, results above 131071 SHALL clamp to 0x1FFFF and results below -131072 SHALL clamp to 0x20000 (AP_SAT).
REQ-030 Without MOTOR_DENSE_SAT_EN, the result SHALL keep the low DATA_W bits (AP_WRAP); all other behaviour SHALL be identical.

Verification
REQ-031 N_IN=8, b=0, all x=2048 (1.0), all w0=2048, w1=-1024 -> ap_return_0=16384, ap_return_1=-8192, ap_done exactly at cycle 10 after start.
REQ-032 b0=1024, b1=-1024, all x=0 -> ap_return_0=1024, ap_return_1=-1024.
REQ-033 x_valid toggling 1/0 each cycle, vectors as REQ-031 -> same results, ap_done at cycle 18.
REQ-034 x=131071, w0=131071 all 8 -> SAT_EN: ap_return_0=131071; without: low 18 bits of the exact sum >>>11.
REQ-035 ap_rst_n pulsed low after the 4th transfer, then a full REQ-031 run -> all outputs 0 during reset, then REQ-031 results; ap_start pulses issued during ACC -> ignored, single ap_done.
